// File: rtl/chime_pkg.sv
// Shared types and decode tables for the chime sequencer: FSM states, tone codes,
// half-period LUT (24 MHz clock) and duration decode.
package chime_pkg;

    localparam int THRESH_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PLAY,
`ifdef CHIME_GAP_EN
        ST_GAP,
`endif
        ST_FINISH
    } state_t;

    localparam logic [3:0] TONE_A3   = 4'd0;
    localparam logic [3:0] TONE_A4   = 4'd7;
    localparam logic [3:0] TONE_A5   = 4'd14;
    localparam logic [3:0] TONE_REST = 4'd15;

    function automatic logic [THRESH_W-1:0] half_period_lut(input logic [3:0] code);
        logic [THRESH_W-1:0] thr;
        unique case (code)
            4'd0:    thr = 16'd54544;
            4'd1:    thr = 16'd48582;
            4'd2:    thr = 16'd45801;
            4'd3:    thr = 16'd40815;
            4'd4:    thr = 16'd36363;
            4'd5:    thr = 16'd34383;
            4'd6:    thr = 16'd30611;
            4'd7:    thr = 16'd27272;
            4'd8:    thr = 16'd24290;
            4'd9:    thr = 16'd22944;
            4'd10:   thr = 16'd20442;
            4'd11:   thr = 16'd18208;
            4'd12:   thr = 16'd17191;
            4'd13:   thr = 16'd15305;
            4'd14:   thr = 16'd13635;
            default: thr = 16'd0;
        endcase
        return thr;
    endfunction

    // A zero threshold would toggle every cycle regardless of the shift, so floor at 1.
    function automatic logic [THRESH_W-1:0] eff_thresh(input logic [3:0] code, input int shift);
        logic [THRESH_W-1:0] v;
        v = half_period_lut(code) >> shift;
        return (v == '0) ? 16'd1 : v;
    endfunction

    function automatic logic [9:0] dur_decode(input logic [3:0] code);
        logic [9:0] ms;
        if (code <= 4'd4)       ms = 10'd1000;
        else if (code <= 4'd10) ms = 10'd500;
        else                    ms = 10'd250;
        return ms;
    endfunction

endpackage

// File: rtl/chime_square_gen.sv
// Half-period counter and toggle; restart holds counter and output at zero.
module square_gen
    import chime_pkg::*;
(
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                restart_i,
    input  logic [THRESH_W-1:0] thr_i,
    input  logic                mute_i,
    output logic                pwm_o
);

    logic [THRESH_W-1:0] cnt_q, cnt_d;
    logic                pwm_q, pwm_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        pwm_d = pwm_q;
        if (restart_i) begin
            cnt_d = '0;
            pwm_d = 1'b0;
        end else if (cnt_q >= thr_i) begin
            cnt_d = '0;
            pwm_d = ~pwm_q;
        end
        if (mute_i) pwm_d = 1'b0;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
            pwm_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            pwm_q <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/chime_sequencer.sv
// Plays NUM_NOTES (tone, duration) pairs reps+1 times on a square-wave pin with start/busy/done.
// Define CHIME_GAP_EN to insert a silent GAP_MS gap between consecutive notes.
module chime_sequencer
    import chime_pkg::*;
#(
    parameter int NUM_NOTES    = 4,
    parameter int CLK_PER_MS   = 24000,
    parameter int THRESH_SHIFT = 0,
    parameter int REP_W        = 8,
`ifdef CHIME_GAP_EN
    parameter int GAP_MS       = 20,
`endif
    localparam int IDX_W = (NUM_NOTES > 1) ? $clog2(NUM_NOTES) : 1
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   start_i,
    input  logic [4*NUM_NOTES-1:0] tones_i,
    input  logic [4*NUM_NOTES-1:0] durs_i,
    input  logic [REP_W-1:0]       reps_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [IDX_W-1:0]       note_idx_o,
    output logic                   pwm_o
);

    localparam int               PRE_W    = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_PER_MS - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NOTES - 1);

    state_t                 state_q, state_d;
    logic [4*NUM_NOTES-1:0] tones_q, tones_d;
    logic [4*NUM_NOTES-1:0] durs_q, durs_d;
    logic [REP_W-1:0]       reps_q, reps_d;
    logic [REP_W-1:0]       pass_q, pass_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [PRE_W-1:0]       pre_q, pre_d;
    logic [9:0]             ms_q, ms_d;

    logic [3:0]             tone_cur, dur_cur;
    logic [THRESH_W-1:0]    thr;
    logic                   tick, note_end, gap_end, last_note;
    logic                   busy, done, restart, mute;

    always_comb begin
        tone_cur = '0;
        dur_cur  = '0;
        for (int i = 0; i < NUM_NOTES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                tone_cur = tones_q[4*(NUM_NOTES-1-i) +: 4];
                dur_cur  = durs_q[4*(NUM_NOTES-1-i) +: 4];
            end
        end
    end

    assign tick      = (pre_q == PRE_LAST);
    assign note_end  = (state_q == ST_PLAY) && tick && (ms_q == dur_decode(dur_cur) - 10'd1);
    assign last_note = (idx_q == LAST_IDX) && !(pass_q < reps_q);
`ifdef CHIME_GAP_EN
    assign gap_end   = (state_q == ST_GAP) && tick && (ms_q == 10'(GAP_MS - 1));
`else
    assign gap_end   = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (start_i) state_d = ST_LOAD;
            ST_LOAD:   state_d = ST_PLAY;
            ST_PLAY: begin
                if (note_end) begin
                    if (last_note) state_d = ST_FINISH;
`ifdef CHIME_GAP_EN
                    else           state_d = ST_GAP;
`endif
                end
            end
`ifdef CHIME_GAP_EN
            ST_GAP:    if (gap_end) state_d = ST_PLAY;
`endif
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == ST_LOAD) || (state_q == ST_PLAY);
`ifdef CHIME_GAP_EN
        if (state_q == ST_GAP) busy = 1'b1;
`endif
        done = (state_q == ST_FINISH);
    end

    // Config is sampled in the LOAD cycle; afterwards input changes are invisible.
    always_comb begin
        tones_d = tones_q;
        durs_d  = durs_q;
        reps_d  = reps_q;
        pass_d  = pass_q;
        idx_d   = idx_q;
        pre_d   = '0;
        ms_d    = '0;
        if (state_q == ST_LOAD) begin
            tones_d = tones_i;
            durs_d  = durs_i;
            reps_d  = reps_i;
            pass_d  = '0;
            idx_d   = '0;
        end else if (busy) begin
            pre_d = tick ? '0 : pre_q + 1'b1;
            if (note_end || gap_end) ms_d = '0;
            else if (tick)           ms_d = ms_q + 1'b1;
            else                     ms_d = ms_q;
            if (note_end) begin
                if (idx_q != LAST_IDX) begin
                    idx_d = idx_q + 1'b1;
                end else if (pass_q < reps_q) begin
                    pass_d = pass_q + 1'b1;
                    idx_d  = '0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            tones_q <= '0;
            durs_q  <= '0;
            reps_q  <= '0;
            pass_q  <= '0;
            idx_q   <= '0;
            pre_q   <= '0;
            ms_q    <= '0;
        end else begin
            tones_q <= tones_d;
            durs_q  <= durs_d;
            reps_q  <= reps_d;
            pass_q  <= pass_d;
            idx_q   <= idx_d;
            pre_q   <= pre_d;
            ms_q    <= ms_d;
        end
    end

    // Tone counter is held cleared outside PLAY and on each note end, so every note starts at phase 0.
    assign restart = (state_q != ST_PLAY) || note_end;
    assign mute    = (tone_cur == TONE_REST);
    assign thr     = eff_thresh(tone_cur, THRESH_SHIFT);

    square_gen u_square_gen (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .restart_i (restart),
        .thr_i     (thr),
        .mute_i    (mute),
        .pwm_o     (pwm_o)
    );

    assign busy_o     = busy;
    assign done_o     = done;
    assign note_idx_o = idx_q;

endmodule

// File: tb/tb_chime_sequencer.sv
// Bench for chime_sequencer: directed table plus randomized runs against a per-note timing model.
module tb_chime_sequencer;

    localparam int CPM = 10;
`ifdef CHIME_GAP_EN
    localparam int GAPC = 20;
`else
    localparam int GAPC = 0;
`endif
    localparam int LUT [16] = '{54544, 48582, 45801, 40815, 36363, 34383, 30611, 27272,
                                24290, 22944, 20442, 18208, 17191, 15305, 13635, 0};

    logic        clk = 1'b0;
    logic        reset_i;
    logic        start_i;
    logic [15:0] tones_i;
    logic [15:0] durs_i;
    logic [7:0]  reps_i;
    logic        busy_o, done_o, pwm_o;
    logic [1:0]  note_idx_o;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    chime_sequencer #(
        .NUM_NOTES    (4),
        .CLK_PER_MS   (CPM),
        .THRESH_SHIFT (10),
        .REP_W        (8)
`ifdef CHIME_GAP_EN
        , .GAP_MS     (2)
`endif
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .start_i    (start_i),
        .tones_i    (tones_i),
        .durs_i     (durs_i),
        .reps_i     (reps_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .note_idx_o (note_idx_o),
        .pwm_o      (pwm_o)
    );

    function automatic int half_cycles(input int code);
        int thr;
        thr = LUT[code] >> 10;
        if (thr < 1) thr = 1;
        return thr + 1;
    endfunction

    function automatic int dur_cycles(input int code);
        if (code <= 4)  return 1000 * CPM;
        if (code <= 10) return 500 * CPM;
        return 250 * CPM;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic trace_result(input string name, input int bad, input string first);
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL %s: %0d bad cycles, required 0 (first: %s)", name, bad, first);
        end
    endtask

    // Caller is just past a negedge; start is raised now and sampled at the next posedge.
    task automatic run_seq(input string tag, input logic [15:0] tn, input logic [15:0] du,
                           input logic [7:0] rp, input bit hassle,
                           output int busy_cnt, output int notes_seen,
                           output int half0, output int done_cnt);
        int    bad, prev_idx, code, len, h, exp_pwm, nxt;
        string first;
        busy_cnt = 0; notes_seen = 0; half0 = 0; done_cnt = 0;
        tones_i = tn; durs_i = du; reps_i = rp; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check({tag, " load busy"}, int'(busy_o), 1);
        check({tag, " load pwm"}, int'(pwm_o), 0);
        busy_cnt += int'(busy_o);
        done_cnt += int'(done_o);
        prev_idx = -1;
        for (int p = 0; p <= int'(rp); p++) begin
            for (int n = 0; n < 4; n++) begin
                code = int'(tn[4*(3-n) +: 4]);
                len  = dur_cycles(int'(du[4*(3-n) +: 4]));
                h    = half_cycles(code);
                bad  = 0;
                first = "";
                for (int t = 0; t < len; t++) begin
                    @(negedge clk);
                    exp_pwm = (code == 15) ? 0 : ((t / h) % 2);
                    busy_cnt += int'(busy_o);
                    done_cnt += int'(done_o);
                    if (int'(note_idx_o) != prev_idx) begin
                        notes_seen++;
                        prev_idx = int'(note_idx_o);
                    end
                    if (p == 0 && n == 0 && half0 == 0 && pwm_o) half0 = t;
                    if (busy_o !== 1'b1 || done_o !== 1'b0 || int'(note_idx_o) != n
                        || int'(pwm_o) != exp_pwm) begin
                        if (bad == 0)
                            first = $sformatf("t=%0d busy=%0d done=%0d idx=%0d pwm=%0d, required busy=1 done=0 idx=%0d pwm=%0d",
                                              t, busy_o, done_o, note_idx_o, pwm_o, n, exp_pwm);
                        bad++;
                    end
                    if (hassle) begin
                        start_i = 1'($urandom_range(0, 1));
                        tones_i = 16'($urandom);
                        durs_i  = 16'($urandom);
                        reps_i  = 8'($urandom);
                    end
                end
                trace_result($sformatf("%s pass%0d note%0d", tag, p, n), bad, first);
`ifdef CHIME_GAP_EN
                if (p < int'(rp) || n < 3) begin
                    nxt = (n + 1) % 4;
                    bad = 0;
                    first = "";
                    for (int g = 0; g < GAPC; g++) begin
                        @(negedge clk);
                        busy_cnt += int'(busy_o);
                        if (int'(note_idx_o) != prev_idx) begin
                            notes_seen++;
                            prev_idx = int'(note_idx_o);
                        end
                        if (busy_o !== 1'b1 || int'(note_idx_o) != nxt || pwm_o !== 1'b0) begin
                            if (bad == 0)
                                first = $sformatf("g=%0d busy=%0d idx=%0d pwm=%0d, required busy=1 idx=%0d pwm=0",
                                                  g, busy_o, note_idx_o, pwm_o, nxt);
                            bad++;
                        end
                    end
                    trace_result($sformatf("%s gap after pass%0d note%0d", tag, p, n), bad, first);
                end
`else
                nxt = n;
`endif
            end
        end
        @(negedge clk);
        busy_cnt += int'(busy_o);
        done_cnt += int'(done_o);
        check({tag, " finish done"}, int'(done_o), 1);
        check({tag, " finish busy"}, int'(busy_o), 0);
        check({tag, " finish pwm"}, int'(pwm_o), 0);
        if (hassle) start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        done_cnt += int'(done_o);
        check({tag, " after-finish busy"}, int'(busy_o), 0);
    endtask

    typedef struct {
        logic [15:0] tones;
        logic [15:0] durs;
        logic [7:0]  reps;
        bit          hassle;
        int          exp_busy;
        int          exp_notes;
        int          exp_half0;
    } vec_t;

    initial begin
        vec_t        vecs [3];
        int          bc, ns, h0, dc, bad, exp_busy;
        logic [15:0] rt;

        vecs[0] = '{16'h7777, 16'hFFFF, 8'd0, 1'b0, 1 + 4 * 2500 + 3 * GAPC, 4, 27};
        vecs[1] = '{16'hE70F, 16'hBBBB, 8'd2, 1'b0, 1 + 12 * 2500 + 11 * GAPC, 12, 14};
        vecs[2] = '{16'h0FEF, 16'hFFFF, 8'd0, 1'b1, 1 + 4 * 2500 + 3 * GAPC, 4, 54};

        reset_i = 1'b1;
        start_i = 1'b0;
        tones_i = '0;
        durs_i  = '0;
        reps_i  = '0;
        #2;
        check("reset busy", int'(busy_o), 0);
        check("reset done", int'(done_o), 0);
        check("reset idx", int'(note_idx_o), 0);
        check("reset pwm", int'(pwm_o), 0);
        repeat (3) @(negedge clk);
        reset_i = 1'b0;
        repeat (3) @(negedge clk);
        check("idle busy", int'(busy_o), 0);

        for (int i = 0; i < 3; i++) begin
            run_seq($sformatf("vec%0d", i), vecs[i].tones, vecs[i].durs, vecs[i].reps,
                    vecs[i].hassle, bc, ns, h0, dc);
            check($sformatf("vec%0d busy cycles", i), bc, vecs[i].exp_busy);
            check($sformatf("vec%0d notes", i), ns, vecs[i].exp_notes);
            check($sformatf("vec%0d half period", i), h0, vecs[i].exp_half0);
            check($sformatf("vec%0d done pulses", i), dc, 1);
        end

        // Random tones with every duration-band boundary; starts one cycle after the previous done.
        rt = 16'($urandom);
        run_seq("rand", rt, 16'h45AB, 8'd0, 1'b1, bc, ns, h0, dc);
        exp_busy = 1 + 3 * GAPC;
        for (int n = 0; n < 4; n++) exp_busy += dur_cycles(n == 0 ? 4 : n == 1 ? 5 : n == 2 ? 10 : 11);
        check("rand busy cycles", bc, exp_busy);
        check("rand done pulses", dc, 1);

        // Asynchronous reset in the middle of note 2 while pwm is high.
        tones_i = 16'h7777; durs_i = 16'hBBBB; reps_i = 8'd0; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (2 * 2500 + 2 * GAPC + 31) @(negedge clk);
        check("pre-reset idx", int'(note_idx_o), 2);
        check("pre-reset pwm", int'(pwm_o), 1);
        #1 reset_i = 1'b1;
        #1;
        check("mid-play reset busy", int'(busy_o), 0);
        check("mid-play reset pwm", int'(pwm_o), 0);
        check("mid-play reset idx", int'(note_idx_o), 0);
        repeat (2) @(negedge clk);
        reset_i = 1'b0;
        bad = 0;
        repeat (60) begin
            @(negedge clk);
            if (busy_o || done_o || pwm_o || note_idx_o != 2'd0) bad++;
        end
        check("post-reset quiet cycles with activity", bad, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
